// File: rtl/memwb_stage_skid.sv
// MEM/WB pipeline stage with valid/ready handshake and 2-entry skid buffer.
// Holds load data, ALU result, rd and writeback control for the WB stage.
module memwb_stage_skid #(
  parameter int XLEN          = 64,
  parameter int RD_W          = 5,
  parameter int CTRL_W        = 2,
  parameter bit ZERO_REG_KILL = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_read_data,
  input  logic [XLEN-1:0]   in_alu_result,
  input  logic [RD_W-1:0]   in_rd,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_read_data,
  output logic [XLEN-1:0]   out_alu_result,
  output logic [RD_W-1:0]   out_rd,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [XLEN-1:0]   out_wb_data,
  output logic              out_regwrite
);

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ONE   = 2'd1;
  localparam logic [1:0] S_TWO   = 2'd2;

  logic [1:0]        r_state;
  logic [XLEN-1:0]   r_m_rdata;
  logic [XLEN-1:0]   r_m_alu;
  logic [RD_W-1:0]   r_m_rd;
  logic [CTRL_W-1:0] r_m_ctrl;
  logic [XLEN-1:0]   r_s_rdata;
  logic [XLEN-1:0]   r_s_alu;
  logic [RD_W-1:0]   r_s_rd;
  logic [CTRL_W-1:0] r_s_ctrl;

  logic              w_accept;
  logic              w_consume;
  logic              w_kill;
  logic [CTRL_W-1:0] w_in_ctrl;

  assign in_ready  = (r_state != S_TWO);
  assign out_valid = (r_state != S_EMPTY);
  assign w_accept  = in_valid & in_ready;
  assign w_consume = out_valid & out_ready;
  assign w_kill    = ZERO_REG_KILL & (in_rd == '0);

  // Writes to x0 are neutralised before they are stored
  always_comb begin
    w_in_ctrl    = in_ctrl;
    w_in_ctrl[0] = in_ctrl[0] & ~w_kill;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= S_EMPTY;
      r_m_rdata <= '0;
      r_m_alu   <= '0;
      r_m_rd    <= '0;
      r_m_ctrl  <= '0;
      r_s_rdata <= '0;
      r_s_alu   <= '0;
      r_s_rd    <= '0;
      r_s_ctrl  <= '0;
    end else if (flush) begin
      r_state <= S_EMPTY;
    end else begin
      unique case (r_state)
        S_EMPTY: begin
          if (w_accept) begin
            r_m_rdata <= in_read_data;
            r_m_alu   <= in_alu_result;
            r_m_rd    <= in_rd;
            r_m_ctrl  <= w_in_ctrl;
            r_state   <= S_ONE;
          end
        end
        S_ONE: begin
          if (w_accept && w_consume) begin
            r_m_rdata <= in_read_data;
            r_m_alu   <= in_alu_result;
            r_m_rd    <= in_rd;
            r_m_ctrl  <= w_in_ctrl;
          end else if (w_accept) begin
            r_s_rdata <= in_read_data;
            r_s_alu   <= in_alu_result;
            r_s_rd    <= in_rd;
            r_s_ctrl  <= w_in_ctrl;
            r_state   <= S_TWO;
          end else if (w_consume) begin
            r_state <= S_EMPTY;
          end
        end
        S_TWO: begin
          if (w_consume) begin
            r_m_rdata <= r_s_rdata;
            r_m_alu   <= r_s_alu;
            r_m_rd    <= r_s_rd;
            r_m_ctrl  <= r_s_ctrl;
            r_state   <= S_ONE;
          end
        end
        default: r_state <= S_EMPTY;
      endcase
    end
  end

  assign out_read_data  = r_m_rdata;
  assign out_alu_result = r_m_alu;
  assign out_rd         = r_m_rd;
  assign out_ctrl       = r_m_ctrl;
  assign out_wb_data    = r_m_ctrl[1] ? r_m_rdata : r_m_alu;
  assign out_regwrite   = out_valid & r_m_ctrl[0];

endmodule

// File: tb/tb_memwb_stage_skid.sv
// Bench for memwb_stage_skid: directed plan steps then random traffic,
// checked against a queue-based FIFO reference of capacity two.
module tb_memwb_stage_skid;

  typedef struct {
    logic [63:0] rdat;
    logic [63:0] alu;
    logic [4:0]  rd;
    logic [1:0]  ctrl;
  } entry_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic [63:0] in_read_data;
  logic [63:0] in_alu_result;
  logic [4:0]  in_rd;
  logic [1:0]  in_ctrl;
  logic        out_ready;

  logic        k_in_ready, k_out_valid, k_regwrite;
  logic [63:0] k_rdat, k_alu, k_wb;
  logic [4:0]  k_rd;
  logic [1:0]  k_ctrl;
  logic        n_in_ready, n_out_valid, n_regwrite;
  logic [63:0] n_rdat, n_alu, n_wb;
  logic [4:0]  n_rd;
  logic [1:0]  n_ctrl;

  int checks = 0;
  int errors = 0;

  entry_t q[$];
  bit     zero_data;

  always #5 clk = ~clk;

  memwb_stage_skid #(
    .XLEN(64), .RD_W(5), .CTRL_W(2), .ZERO_REG_KILL(1'b1)
  ) dut_k (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(k_in_ready),
    .in_read_data(in_read_data), .in_alu_result(in_alu_result),
    .in_rd(in_rd), .in_ctrl(in_ctrl),
    .out_valid(k_out_valid), .out_ready(out_ready),
    .out_read_data(k_rdat), .out_alu_result(k_alu),
    .out_rd(k_rd), .out_ctrl(k_ctrl),
    .out_wb_data(k_wb), .out_regwrite(k_regwrite)
  );

  memwb_stage_skid #(
    .XLEN(64), .RD_W(5), .CTRL_W(2), .ZERO_REG_KILL(1'b0)
  ) dut_n (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(n_in_ready),
    .in_read_data(in_read_data), .in_alu_result(in_alu_result),
    .in_rd(in_rd), .in_ctrl(in_ctrl),
    .out_valid(n_out_valid), .out_ready(out_ready),
    .out_read_data(n_rdat), .out_alu_result(n_alu),
    .out_rd(n_rd), .out_ctrl(n_ctrl),
    .out_wb_data(n_wb), .out_regwrite(n_regwrite)
  );

  function automatic entry_t mk(logic [63:0] r, logic [63:0] a,
                                logic [4:0] rd, logic [1:0] c);
    entry_t e;
    e.rdat = r;
    e.alu  = a;
    e.rd   = rd;
    e.ctrl = c;
    return e;
  endfunction

  function automatic entry_t rnd();
    entry_t e;
    e.rdat = {$urandom, $urandom};
    e.alu  = {$urandom, $urandom};
    e.rd   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
    e.ctrl = 2'($urandom);
    return e;
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic compare();
    entry_t h;
    logic [63:0] wb;
    logic [1:0] kc;
    chk("k_in_ready", 64'(k_in_ready), 64'(q.size() < 2));
    chk("n_in_ready", 64'(n_in_ready), 64'(q.size() < 2));
    chk("k_out_valid", 64'(k_out_valid), 64'(q.size() > 0));
    chk("n_out_valid", 64'(n_out_valid), 64'(q.size() > 0));
    if (q.size() > 0) begin
      h  = q[0];
      wb = h.ctrl[1] ? h.rdat : h.alu;
      kc = h.ctrl;
      if (h.rd == 5'd0) kc[0] = 1'b0;
      chk("k_rdat", k_rdat, h.rdat);
      chk("k_alu", k_alu, h.alu);
      chk("k_rd", 64'(k_rd), 64'(h.rd));
      chk("k_ctrl", 64'(k_ctrl), 64'(kc));
      chk("k_wb", k_wb, wb);
      chk("k_regwrite", 64'(k_regwrite), 64'(kc[0]));
      chk("n_wb", n_wb, wb);
      chk("n_ctrl", 64'(n_ctrl), 64'(h.ctrl));
      chk("n_regwrite", 64'(n_regwrite), 64'(h.ctrl[0]));
    end else begin
      chk("k_regwrite_idle", 64'(k_regwrite), 64'd0);
      chk("n_regwrite_idle", 64'(n_regwrite), 64'd0);
      if (zero_data) begin
        chk("k_wb_rst", k_wb, 64'd0);
        chk("k_rd_rst", 64'(k_rd), 64'd0);
        chk("n_wb_rst", n_wb, 64'd0);
      end
    end
  endtask

  task automatic step(bit rn, bit fl, bit iv, entry_t e, bit ordy);
    bit acc, con;
    reset         = rn;
    flush         = fl;
    in_valid      = iv;
    in_read_data  = e.rdat;
    in_alu_result = e.alu;
    in_rd         = e.rd;
    in_ctrl       = e.ctrl;
    out_ready     = ordy;
    acc = iv && (q.size() < 2);
    con = ordy && (q.size() > 0);
    @(posedge clk);
    if (!rn) begin
      q.delete();
      zero_data = 1'b1;
    end else if (fl) begin
      q.delete();
    end else begin
      if (con) void'(q.pop_front());
      if (acc) begin
        q.push_back(e);
        zero_data = 1'b0;
      end
    end
    #1;
    compare();
  endtask

  initial begin
    entry_t z;
    z = mk(64'd0, 64'd0, 5'd0, 2'd0);
    zero_data = 1'b1;
    step(0, 0, 0, z, 0);
    step(0, 1, 1, mk(64'h55, 64'h66, 5'd3, 2'd1), 1);
    // streaming
    step(1, 0, 1, mk(64'h1, 64'h10, 5'd1, 2'b01), 1);
    step(1, 0, 1, mk(64'h2, 64'h20, 5'd2, 2'b01), 1);
    step(1, 0, 1, mk(64'h3, 64'h30, 5'd3, 2'b01), 1);
    step(1, 0, 0, z, 1);
    // back-pressure
    step(1, 0, 1, mk(64'h0, 64'hA, 5'd4, 2'b01), 0);
    step(1, 0, 1, mk(64'h0, 64'hB, 5'd5, 2'b01), 0);
    step(1, 0, 1, mk(64'h0, 64'hC, 5'd6, 2'b01), 0);
    step(1, 0, 0, z, 1);
    step(1, 0, 0, z, 1);
    step(1, 0, 0, z, 1);
    // load select
    step(1, 0, 1, mk(64'hDEAD_BEEF, 64'h1234, 5'd7, 2'b11), 1);
    step(1, 0, 1, mk(64'hDEAD_BEEF, 64'h1234, 5'd7, 2'b01), 1);
    // x0 kill
    step(1, 0, 1, mk(64'h9, 64'h99, 5'd0, 2'b01), 1);
    step(1, 0, 0, z, 0);
    step(1, 0, 0, z, 1);
    // flush from TWO with an incoming entry
    step(1, 0, 1, mk(64'h1, 64'hF1, 5'd8, 2'b01), 0);
    step(1, 0, 1, mk(64'h2, 64'hF2, 5'd9, 2'b01), 0);
    step(1, 1, 1, mk(64'h3, 64'hF3, 5'd10, 2'b01), 0);
    step(1, 0, 0, z, 1);
    step(1, 0, 1, mk(64'h4, 64'hF4, 5'd11, 2'b11), 1);
    // reset mid-stream
    step(1, 0, 1, mk(64'h5, 64'hE5, 5'd12, 2'b11), 0);
    step(0, 0, 0, z, 0);
    step(1, 0, 1, mk(64'h6, 64'hE6, 5'd13, 2'b01), 0);
    step(1, 0, 0, z, 1);
    // random traffic
    for (int i = 0; i < 400; i++) begin
      bit rn, fl;
      rn = ($urandom_range(0, 49) != 0);
      fl = ($urandom_range(0, 19) == 0);
      step(rn, fl, 1'($urandom), rnd(), 1'($urandom));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
